// File: rtl/uart_frame_writer.sv
// uart_frame_writer
// Turns the framed byte stream from the UART receiver into addressed byte
// writes: SYNC, ADDR_HI, ADDR_LO, LEN, LEN payload bytes, CSUM. Each payload
// byte becomes one write; the XOR checksum decides between frame_done and
// frame_error. Overrun and inter-byte timeout abort the frame.
module uart_frame_writer #(
    parameter int               DBITS          = 8,
    parameter int               ADDR_WIDTH     = 16,
    parameter logic [DBITS-1:0] SYNC_BYTE      = 8'hA5,
    parameter int               TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DBITS-1:0]      rx_data,
    input  logic                  rx_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DBITS-1:0]      mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic [1:0]            err_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // The timer reads 1 in the first cycle after a byte, so comparing against
    // TIMEOUT_CYCLES-2 lands the registered error pulse TIMEOUT_CYCLES-1
    // cycles after the last rx_done.
    localparam logic [TW-1:0]  TIMER_LIMIT = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [DBITS:0] FULL_LEN    = {1'b1, {DBITS{1'b0}}};

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_OVERRUN  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CSUM
    } state_t;

    state_t                r_state, w_nextState;
    logic                  r_memWe, w_memWe;
    logic [ADDR_WIDTH-1:0] r_memAddr, w_memAddr;
    logic [DBITS-1:0]      r_memWdata, w_memWdata;
    logic                  r_frameDone, w_frameDone;
    logic                  r_frameError, w_frameError;
    logic [1:0]            r_errCode, w_errCode;
    logic [DBITS-1:0]      r_addrHi, w_addrHi;
    logic [15:0]           r_base, w_base;
    logic [DBITS:0]        r_len, w_len;
    logic [DBITS:0]        r_index, w_index;
    logic [DBITS-1:0]      r_csum, w_csum;
    logic [TW-1:0]         r_timer, w_timer;

    logic                  w_writeStall;
    logic                  w_timeout;
    logic [DBITS:0]        w_indexInc;

    assign w_writeStall = r_memWe && !mem_ready;
    assign w_timeout    = (r_state != S_IDLE) && !rx_done && (r_timer >= TIMER_LIMIT);
    assign w_indexInc   = r_index + (DBITS+1)'(1);

    assign mem_we      = r_memWe;
    assign mem_addr    = r_memAddr;
    assign mem_wdata   = r_memWdata;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frameDone;
    assign frame_error = r_frameError;
    assign err_code    = r_errCode;

    // State and datapath registers; reset drops any frame or pending write at once.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_frameDone  <= 1'b0;
            r_frameError <= 1'b0;
            r_errCode    <= ERR_NONE;
            r_addrHi     <= '0;
            r_base       <= '0;
            r_len        <= '0;
            r_index      <= '0;
            r_csum       <= '0;
            r_timer      <= '0;
        end else begin
            r_state      <= w_nextState;
            r_memWe      <= w_memWe;
            r_memAddr    <= w_memAddr;
            r_memWdata   <= w_memWdata;
            r_frameDone  <= w_frameDone;
            r_frameError <= w_frameError;
            r_errCode    <= w_errCode;
            r_addrHi     <= w_addrHi;
            r_base       <= w_base;
            r_len        <= w_len;
            r_index      <= w_index;
            r_csum       <= w_csum;
            r_timer      <= w_timer;
        end
    end

    // Next state: advance one field per received byte; timeout and overrun abort to IDLE.
    always_comb begin
        w_nextState = r_state;
        if (w_timeout) begin
            w_nextState = S_IDLE;
        end else if (rx_done) begin
            case (r_state)
                S_IDLE:   if (rx_data == SYNC_BYTE) w_nextState = S_ADDR_H;
                S_ADDR_H: w_nextState = S_ADDR_L;
                S_ADDR_L: w_nextState = S_LEN;
                S_LEN:    w_nextState = S_DATA;
                S_DATA: begin
                    if (w_writeStall)              w_nextState = S_IDLE;
                    else if (w_indexInc == r_len)  w_nextState = S_CSUM;
                end
                S_CSUM:   w_nextState = S_IDLE;
                default:  w_nextState = S_IDLE;
            endcase
        end
    end

    // Outputs and datapath: latch header fields, issue writes, fold the checksum, report results.
    always_comb begin
        w_memWe      = r_memWe && !mem_ready;
        w_memAddr    = r_memAddr;
        w_memWdata   = r_memWdata;
        w_frameDone  = 1'b0;
        w_frameError = 1'b0;
        w_errCode    = r_errCode;
        w_addrHi     = r_addrHi;
        w_base       = r_base;
        w_len        = r_len;
        w_index      = r_index;
        w_csum       = r_csum;

        if (w_nextState == S_IDLE)  w_timer = '0;
        else if (rx_done)           w_timer = TW'(1);
        else                        w_timer = r_timer + TW'(1);

        if (w_timeout) begin
            w_memWe      = 1'b0;
            w_frameError = 1'b1;
            w_errCode    = ERR_TIMEOUT;
        end else if (rx_done) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        w_errCode = ERR_NONE;
                        w_csum    = '0;
                    end
                end
                S_ADDR_H: begin
                    w_addrHi = rx_data;
                    w_csum   = r_csum ^ rx_data;
                end
                S_ADDR_L: begin
                    w_base = 16'({r_addrHi, rx_data});
                    w_csum = r_csum ^ rx_data;
                end
                S_LEN: begin
                    w_len   = (rx_data == '0) ? FULL_LEN : {1'b0, rx_data};
                    w_index = '0;
                    w_csum  = r_csum ^ rx_data;
                end
                S_DATA: begin
                    if (w_writeStall) begin
                        w_memWe      = 1'b0;
                        w_frameError = 1'b1;
                        w_errCode    = ERR_OVERRUN;
                    end else begin
                        w_memWe    = 1'b1;
                        w_memWdata = rx_data;
                        w_memAddr  = ADDR_WIDTH'(32'(r_base) + 32'(r_index));
                        w_csum     = r_csum ^ rx_data;
                        w_index    = w_indexInc;
                    end
                end
                S_CSUM: begin
                    if (w_writeStall) begin
                        w_memWe      = 1'b0;
                        w_frameError = 1'b1;
                        w_errCode    = ERR_OVERRUN;
                    end else if (r_csum == rx_data) begin
                        w_frameDone = 1'b1;
                    end else begin
                        w_frameError = 1'b1;
                        w_errCode    = ERR_CHECKSUM;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_writer.sv
// tb_uart_frame_writer
// Directed and randomized frames against a queue-based model of the framing
// protocol: expected writes are (base+i) mod 2^16 with the payload bytes, and
// the frame result follows from XOR-ing the header and payload bytes.
module tb_uart_frame_writer;

    localparam int TIMEOUT = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        frame_done;
    logic        frame_error;
    logic [1:0]  err_code;

    int   asserts  = 0;
    int   failures = 0;
    int   readyMode = 0;
    logic readyForce = 1'b1;
    int   doneCnt = 0;
    int   errCnt  = 0;

    logic [15:0] gotAddr[$];
    logic [7:0]  gotData[$];
    logic [7:0]  payload[$];

    uart_frame_writer #(
        .DBITS(8),
        .ADDR_WIDTH(16),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .busy(busy),
        .frame_done(frame_done),
        .frame_error(frame_error),
        .err_code(err_code)
    );

    // Free-running clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        asserts++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One received byte: a single-cycle rx_done pulse followed by idle cycles
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        @(posedge clock); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clock); #1;
        rx_done = 1'b0;
        repeat (gap) @(posedge clock);
    endtask

    // Backpressure: either a forced level, or random with at most one low cycle in a row
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            if (readyMode == 0)  mem_ready = readyForce;
            else if (!mem_ready) mem_ready = 1'b1;
            else                 mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: collect accepted writes and result pulses on the falling edge
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (mem_we && mem_ready) begin
                    gotAddr.push_back(mem_addr);
                    gotData.push_back(mem_wdata);
                end
                if (frame_done)  doneCnt++;
                if (frame_error) errCnt++;
                if (frame_done || frame_error)
                    checkOutput("pulse_exclusive", 32'(frame_done & frame_error), 32'd0);
            end
        end
    end

    // Send a whole frame from the payload queue and compare against the model
    task automatic runFrame(input logic [15:0] base, input int n, input bit forceCsum, input logic [7:0] csumValue);
        logic [7:0]  lenByte;
        logic [7:0]  sum;
        logic [7:0]  csum;
        bit          good;
        logic [15:0] expAddr[$];
        logic [7:0]  expData[$];
        int          waitCycles;
        int          cmpCount;

        lenByte = 8'(n);
        sum = base[15:8] ^ base[7:0] ^ lenByte;
        for (int i = 0; i < n; i++) begin
            sum ^= payload[i];
            expAddr.push_back(16'((int'(base) + i) % 65536));
            expData.push_back(payload[i]);
        end
        csum = forceCsum ? csumValue : sum;
        good = (csum == sum);

        gotAddr.delete();
        gotData.delete();
        doneCnt = 0;
        errCnt  = 0;

        applyStimulus(8'hA5, $urandom_range(1, 3));
        applyStimulus(base[15:8], $urandom_range(1, 3));
        applyStimulus(base[7:0], $urandom_range(1, 3));
        applyStimulus(lenByte, $urandom_range(1, 3));
        for (int i = 0; i < n; i++)
            applyStimulus(payload[i], $urandom_range(1, 3));
        applyStimulus(csum, 0);

        waitCycles = 0;
        @(negedge clock);
        while (busy && waitCycles < 20) begin
            @(negedge clock);
            waitCycles++;
        end
        repeat (2) @(posedge clock);
        #1;

        checkOutput("frame_end_busy", 32'(busy), 32'd0);
        checkOutput("write_count", 32'(gotAddr.size()), 32'(expAddr.size()));
        cmpCount = (gotAddr.size() < expAddr.size()) ? gotAddr.size() : expAddr.size();
        for (int i = 0; i < cmpCount; i++) begin
            checkOutput($sformatf("write_addr[%0d]", i), 32'(gotAddr[i]), 32'(expAddr[i]));
            checkOutput($sformatf("write_data[%0d]", i), 32'(gotData[i]), 32'(expData[i]));
        end
        checkOutput("done_pulses", 32'(doneCnt), good ? 32'd1 : 32'd0);
        checkOutput("error_pulses", 32'(errCnt), good ? 32'd0 : 32'd1);
        checkOutput("err_code", 32'(err_code), good ? 32'd0 : 32'd1);
    endtask

    // Directed sequence followed by randomized frames
    initial begin
        int n;
        int k;

        reset   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset_frame_error", 32'(frame_error), 32'd0);
        checkOutput("reset_err_code", 32'(err_code), 32'd0);

        // Good frame at 0x1234 (its checksum works out to 0x25), then a bad checksum
        readyMode  = 0;
        readyForce = 1'b1;
        payload = '{8'h11, 8'h22, 8'h33};
        runFrame(16'h1234, 3, 1'b0, 8'h00);
        runFrame(16'h1234, 3, 1'b1, 8'h08);

        // Address wrap-around past 0xFFFF
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        runFrame(16'hFFFE, 4, 1'b0, 8'h00);

        // Random frames with random backpressure and occasional bad checksums
        readyMode = 1;
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 24);
            payload.delete();
            for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
            runFrame(16'($urandom), n, ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        // Overrun: second payload byte arrives while the first write is stalled
        readyMode  = 0;
        readyForce = 1'b1;
        gotAddr.delete();
        gotData.delete();
        doneCnt = 0;
        errCnt  = 0;
        applyStimulus(8'hA5, 2);
        applyStimulus(8'h20, 2);
        applyStimulus(8'h00, 2);
        applyStimulus(8'h03, 2);
        readyForce = 1'b0;
        applyStimulus(8'h5A, 1);
        applyStimulus(8'h6B, 0);
        @(negedge clock);
        checkOutput("overrun_frame_error", 32'(frame_error), 32'd1);
        checkOutput("overrun_mem_we", 32'(mem_we), 32'd0);
        checkOutput("overrun_busy", 32'(busy), 32'd0);
        checkOutput("overrun_err_code", 32'(err_code), 32'd2);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("overrun_error_pulses", 32'(errCnt), 32'd1);
        checkOutput("overrun_done_pulses", 32'(doneCnt), 32'd0);
        checkOutput("overrun_writes", 32'(gotAddr.size()), 32'd0);
        readyMode = 1;
        payload.delete();
        for (int i = 0; i < 5; i++) payload.push_back(8'($urandom));
        runFrame(16'($urandom), 5, 1'b0, 8'h00);

        // Bytes other than SYNC are ignored in IDLE; then stall after A5 00
        applyStimulus(8'h00, 1);
        applyStimulus(8'hFF, 1);
        @(negedge clock);
        checkOutput("idle_ignores_bytes", 32'(busy), 32'd0);
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h00, 0);
        k = 1;
        while (k < 300) begin
            @(negedge clock);
            if (frame_error) break;
            @(posedge clock);
            k++;
        end
        checkOutput("timeout_cycle", 32'(k), 32'(TIMEOUT - 1));
        checkOutput("timeout_err_code", 32'(err_code), 32'd3);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        checkOutput("timeout_mem_we", 32'(mem_we), 32'd0);

        // Reset while a write is pending in DATA, then a full 256-byte frame
        readyMode  = 0;
        readyForce = 1'b1;
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h40, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h05, 1);
        readyForce = 1'b0;
        applyStimulus(8'h77, 0);
        @(negedge clock);
        checkOutput("pre_reset_mem_we", 32'(mem_we), 32'd1);
        checkOutput("pre_reset_mem_addr", 32'(mem_addr), 32'h4000);
        checkOutput("pre_reset_mem_wdata", 32'(mem_wdata), 32'h77);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midreset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("midreset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("midreset_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("midreset_frame_error", 32'(frame_error), 32'd0);
        checkOutput("midreset_err_code", 32'(err_code), 32'd0);
        readyMode = 1;
        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'($urandom));
        runFrame(16'($urandom), 256, 1'b0, 8'h00);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
